vt_mux_scan_seq: RTL and testbench

- Sequencer that drives the select (s) and active-low enable (e_n) inputs of an 8-to-1 TTL-style mux, stepping through inputs 0..LEN (or LEN..0).
- Samples the mux output z once per slot and assembles the sampled bits into a parallel word.
- Sits directly upstream of the mux (control) and also consumes its z output. The mux plus this block form a programmable parallel-to-serial scanner with read-back.

---
 rtl/vt_mux_scan_if.sv | 31 +++
 rtl/vt_mux_scan_seq.sv | 152 +++++++++++++++
 tb/tb_vt_mux_scan_seq.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/vt_mux_scan_if.sv
// Control/read-back bundle between the mux scan sequencer and its user.
// The slave side is the sequencer; the master side drives the requests
// and the mux output z, and observes the mux controls and assembled word.
interface vt_mux_scan_if #(
   parameter int DIVW = 8
);
   logic            start;
   logic            stop;
   logic            cont;
   logic            dir;
   logic [2:0]      len;
   logic [DIVW-1:0] div;
   logic            z;
   logic [2:0]      s;
   logic            e_n;
   logic            bit_stb;
   logic            busy;
   logic [7:0]      dout;
   logic            dout_vld;
   logic            frame_done;

   modport master (
      output start, stop, cont, dir, len, div, z,
      input  s, e_n, bit_stb, busy, dout, dout_vld, frame_done
   );

   modport slave (
      input  start, stop, cont, dir, len, div, z,
      output s, e_n, bit_stb, busy, dout, dout_vld, frame_done
   );
endinterface

// File: rtl/vt_mux_scan_seq.sv
// Scan sequencer for an 8-to-1 TTL-style mux: steps the select through
// 0..len (or len..0), holds each slot for div+1 cycles, samples z on the
// last cycle of each slot and publishes the assembled word at frame end.
module vt_mux_scan_seq #(
   parameter int DIVW = 8
) (
   input  logic          clk,
   input  logic          rst,
   vt_mux_scan_if.slave  bus
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t          state_r,  state_s;
   logic [2:0]      s_r,      s_s;
   logic [2:0]      len_sh_r, len_sh_s;
   logic            dir_sh_r, dir_sh_s;
   logic [DIVW-1:0] div_sh_r, div_sh_s;
   logic [DIVW-1:0] presc_r,  presc_s;
   logic [7:0]      cap_r,    cap_s;
   logic [7:0]      dout_r,   dout_s;
   logic            vld_r,    vld_s;
   logic            e_n_r,    e_n_s;
   logic            busy_r,   busy_s;
   logic            tick_s;
   logic            last_s;
   logic [7:0]      merged_s;

   // Mask keeping bits 0..l of the assembled word.
   function automatic logic [7:0] len_mask(input logic [2:0] l);
      logic [7:0] m;
      m = 8'h00;
      for (int k = 0; k < 8; k++) begin
         if (k <= int'(l)) begin
            m[k] = 1'b1;
         end else begin
            m[k] = 1'b0;
         end
      end
      return m;
   endfunction

   // Slot tick, final-slot detect and capture word with the current z merged in.
   always_comb begin
      tick_s   = (state_r == ST_RUN) && (presc_r == {DIVW{1'b0}});
      last_s   = dir_sh_r ? (s_r == 3'd0) : (s_r == len_sh_r);
      merged_s = cap_r;
      merged_s[s_r] = bus.z;
   end

   // Next-state and next-register values for the scan FSM.
   always_comb begin
      state_s  = state_r;
      s_s      = s_r;
      len_sh_s = len_sh_r;
      dir_sh_s = dir_sh_r;
      div_sh_s = div_sh_r;
      presc_s  = presc_r;
      cap_s    = cap_r;
      dout_s   = dout_r;
      vld_s    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (bus.start && !bus.stop) begin
               state_s  = ST_RUN;
               len_sh_s = bus.len;
               dir_sh_s = bus.dir;
               div_sh_s = bus.div;
               s_s      = bus.dir ? bus.len : 3'd0;
               presc_s  = bus.div;
               cap_s    = 8'h00;
            end else begin
               state_s  = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (bus.stop) begin
               // Abort: drop the frame without publishing anything.
               state_s = ST_IDLE;
            end else if (tick_s) begin
               cap_s = merged_s;
               if (last_s) begin
                  dout_s = merged_s & len_mask(len_sh_r);
                  vld_s  = 1'b1;
                  if (bus.cont) begin
                     // Back-to-back frame: fresh settings, no idle gap.
                     len_sh_s = bus.len;
                     dir_sh_s = bus.dir;
                     div_sh_s = bus.div;
                     s_s      = bus.dir ? bus.len : 3'd0;
                     presc_s  = bus.div;
                     cap_s    = 8'h00;
                  end else begin
                     state_s  = ST_IDLE;
                  end
               end else begin
                  s_s     = dir_sh_r ? (s_r - 3'd1) : (s_r + 3'd1);
                  presc_s = div_sh_r;
               end
            end else begin
               presc_s = presc_r - {{(DIVW-1){1'b0}}, 1'b1};
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
      e_n_s  = (state_s != ST_RUN);
      busy_s = (state_s == ST_RUN);
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r  <= ST_IDLE;
         s_r      <= 3'd0;
         len_sh_r <= 3'd0;
         dir_sh_r <= 1'b0;
         div_sh_r <= {DIVW{1'b0}};
         presc_r  <= {DIVW{1'b0}};
         cap_r    <= 8'h00;
         dout_r   <= 8'h00;
         vld_r    <= 1'b0;
         e_n_r    <= 1'b1;
         busy_r   <= 1'b0;
      end else begin
         state_r  <= state_s;
         s_r      <= s_s;
         len_sh_r <= len_sh_s;
         dir_sh_r <= dir_sh_s;
         div_sh_r <= div_sh_s;
         presc_r  <= presc_s;
         cap_r    <= cap_s;
         dout_r   <= dout_s;
         vld_r    <= vld_s;
         e_n_r    <= e_n_s;
         busy_r   <= busy_s;
      end
   end

   assign bus.s          = s_r;
   assign bus.e_n        = e_n_r;
   assign bus.busy       = busy_r;
   assign bus.bit_stb    = tick_s;
   assign bus.dout       = dout_r;
   assign bus.dout_vld   = vld_r;
   assign bus.frame_done = vld_r;

endmodule

// File: tb/tb_vt_mux_scan_seq.sv
// Directed/randomized bench for vt_mux_scan_seq. The mux is modelled as a
// lookup of an 8-bit input map by the select; expected slot positions,
// strobes, latency and words come from frame arithmetic.
module tb_vt_mux_scan_seq;
   localparam int DIVW = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] zmap;
   logic [7:0] exp_dout;
   int         vectors = 0;
   int         miscompares = 0;

   vt_mux_scan_if #(.DIVW(DIVW)) bus ();

   vt_mux_scan_seq #(.DIVW(DIVW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   assign bus.z = zmap[bus.s];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Word a frame of length l+1 must produce: inputs 0..l, zeros above.
   function automatic logic [7:0] ref_word(input logic [7:0] zm, input int l);
      logic [7:0] w;
      w = 8'h00;
      for (int k = 0; k <= l; k++) w[k] = zm[k];
      return w;
   endfunction

   task automatic chk_quiet(input string tag);
      chk({tag, "_e_n"},  bus.e_n, 32'd1);
      chk({tag, "_busy"}, bus.busy, 32'd0);
      chk({tag, "_vld"},  bus.dout_vld, 32'd0);
      chk({tag, "_fd"},   bus.frame_done, 32'd0);
      chk({tag, "_stb"},  bus.bit_stb, 32'd0);
      chk({tag, "_dout"}, bus.dout, 32'(exp_dout));
   endtask

   // One non-continuous frame; optional start re-pulse at cycle restart_at.
   task automatic run_frame(input int l, input bit d, input int dv,
                            input logic [7:0] zm, input int restart_at);
      int lat;
      lat      = 1 + (l + 1) * (dv + 1);
      zmap     = zm;
      bus.len  = 3'(l);
      bus.dir  = d;
      bus.div  = DIVW'(dv);
      bus.cont = 1'b0;
      bus.stop = 1'b0;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      bus.len   = 3'($urandom);
      bus.dir   = 1'($urandom);
      bus.div   = DIVW'($urandom_range(0, 5));
      for (int t = 1; t < lat; t++) begin
         int j;
         int es;
         j  = (t - 1) / (dv + 1);
         es = d ? (l - j) : j;
         chk("run_busy", bus.busy, 32'd1);
         chk("run_e_n",  bus.e_n, 32'd0);
         chk("run_s",    bus.s, 32'(es));
         chk("run_stb",  bus.bit_stb, 32'(((t - 1) % (dv + 1)) == dv));
         chk("run_vld",  bus.dout_vld, 32'd0);
         bus.start = (t == restart_at);
         step();
      end
      bus.start = 1'b0;
      exp_dout  = ref_word(zm, l);
      chk("end_vld",  bus.dout_vld, 32'd1);
      chk("end_fd",   bus.frame_done, 32'd1);
      chk("end_dout", bus.dout, 32'(exp_dout));
      chk("end_e_n",  bus.e_n, 32'd1);
      chk("end_busy", bus.busy, 32'd0);
      chk("end_s",    bus.s, 32'(d ? 0 : l));
      step();
      chk_quiet("post");
   endtask

   initial begin
      int cur_len;
      int next_vld;
      int len_prev;
      int waited;

      rst = 1'b1;
      zmap = 8'h00;
      exp_dout = 8'h00;
      bus.start = 1'b0; bus.stop = 1'b0; bus.cont = 1'b0;
      bus.dir = 1'b0; bus.len = 3'd0; bus.div = {DIVW{1'b0}};
      step();
      step();
      chk_quiet("reset");
      chk("reset_s", bus.s, 32'd0);
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         chk_quiet("idle");
         chk("idle_s", bus.s, 32'd0);
      end

      // Ascending full frame, one cycle per slot.
      run_frame(7, 1'b0, 0, 8'h4D, 0);
      // Descending short frame, three cycles per slot.
      run_frame(3, 1'b1, 2, 8'h04, 0);
      // Start re-pulsed mid-frame must not disturb the frame.
      run_frame(4, 1'b0, 1, 8'($urandom), 5);

      // Continuous mode with a len change taking effect at the next frame.
      zmap = 8'hFF;
      bus.len = 3'd1; bus.dir = 1'b0; bus.div = {DIVW{1'b0}};
      bus.cont = 1'b1; bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      cur_len = 1; next_vld = 3; len_prev = 1;
      for (int t = 1; t <= 16; t++) begin
         chk("cont_e_n", bus.e_n, 32'd0);
         chk("cont_busy", bus.busy, 32'd1);
         chk("cont_vld", bus.dout_vld, 32'(t == next_vld));
         if (t == next_vld) begin
            chk("cont_dout", bus.dout, 32'(ref_word(8'hFF, cur_len)));
            cur_len  = len_prev;
            next_vld = t + cur_len + 1;
         end
         if (t == 5) bus.len = 3'd2;
         len_prev = int'(bus.len);
         step();
      end
      bus.cont = 1'b0;
      waited = 0;
      while (bus.busy === 1'b1 && waited < 8) begin
         step();
         waited++;
      end
      exp_dout = ref_word(8'hFF, 2);
      chk("cont_exit_busy", bus.busy, 32'd0);
      chk("cont_exit_dout", bus.dout, 32'(exp_dout));

      // Abort during slot 4 of a len=7, div=3 frame.
      zmap = 8'($urandom);
      bus.len = 3'd7; bus.dir = 1'b0; bus.div = DIVW'(3);
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      for (int t = 1; t <= 18; t++) begin
         chk("abort_busy", bus.busy, 32'd1);
         if (t == 18) bus.stop = 1'b1;
         step();
      end
      bus.stop = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk_quiet("abort");
         step();
      end
      run_frame(7, 1'b1, 1, 8'($urandom), 0);

      // Stop coinciding with the final tick of a one-slot frame.
      zmap = 8'hFF;
      bus.len = 3'd0; bus.dir = 1'b0; bus.div = {DIVW{1'b0}};
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      chk("final_stop_stb", bus.bit_stb, 32'd1);
      bus.stop = 1'b1;
      step();
      bus.stop = 1'b0;
      chk_quiet("final_stop");
      step();
      chk_quiet("final_stop2");

      // Start and stop together in IDLE: stay idle.
      bus.start = 1'b1; bus.stop = 1'b1;
      step();
      bus.start = 1'b0; bus.stop = 1'b0;
      chk_quiet("start_stop");

      // Randomized frames.
      for (int i = 0; i < 6; i++) begin
         run_frame(int'($urandom_range(0, 7)), 1'($urandom),
                   int'($urandom_range(0, 3)), 8'($urandom), 0);
      end

      // Reset in the middle of a frame.
      zmap = 8'($urandom);
      bus.len = 3'd5; bus.dir = 1'b1; bus.div = DIVW'(1);
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      for (int i = 0; i < 4; i++) step();
      chk("pre_rst_busy", bus.busy, 32'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      exp_dout = 8'h00;
      chk_quiet("mid_rst");
      chk("mid_rst_s", bus.s, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
